// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display: segment bit
// order, the nibble-to-segment table and the special glyphs.
package display_pkg;

    // Bit order of every 7-bit segment vector: {g,f,e,d,c,b,a}.
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

    // Active-high glyphs for 0-9 and A, b, C, d, E, F.
    localparam seg_t SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Converts an active-high pattern to the polarity the pins need.
    function automatic seg_t seg_drive(input seg_t pattern, input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble to active-high 7-segment decoder; non-decimal
// nibbles become a dash when hex display is disabled.
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    output seg_t       o_seg
);

    always_comb begin
        o_seg = SEG_TABLE[i_nibble];
        if (!i_hex_mode && (i_nibble > 4'd9)) begin
            o_seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/display_multiplexado.sv
// Time-multiplexed 7-segment driver: prescaled digit scan, tear-free
// frame updates, leading-zero blanking and selectable segment polarity.
module display_multiplexado
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int HEX_MODE       = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic          ACT_LOW    = (SEG_ACTIVE_LOW != 0);
    localparam seg_t          SEG_OFF    = seg_drive(SEG_BLANK, ACT_LOW);
    localparam logic          DP_OFF     = ACT_LOW;

    logic [PW-1:0]           r_presc;
    logic [PW-1:0]           w_presc_nxt;
    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           w_idx_nxt;
    logic                    w_tick;
    logic                    w_wrap;

    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [4*NUM_DIGITS-1:0] w_act_data_nxt;
    logic [NUM_DIGITS-1:0]   w_act_dp_nxt;

    logic [NUM_DIGITS-1:0]   w_lz;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic                    w_blank;
    seg_t                    w_dec_seg;
    seg_t                    w_seg_hi;

    seg_t                    r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame;

    // Scan timing: the prescaler and index only move while enable is high.
    always_comb begin
        w_tick      = enable && (r_presc == PRESC_LAST);
        w_wrap      = w_tick && (r_idx == IDX_LAST);
        w_presc_nxt = r_presc;
        if (enable) begin
            w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        end
        w_idx_nxt = r_idx;
        if (w_wrap) begin
            w_idx_nxt = '0;
        end else if (w_tick) begin
            w_idx_nxt = r_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // The active copy only changes at the frame boundary, so one frame never
    // mixes old and new digits; a load on that very edge bypasses pending.
    always_comb begin
        w_act_data_nxt = r_act_data;
        w_act_dp_nxt   = r_act_dp;
        if (w_wrap) begin
            w_act_data_nxt = load ? data_in : r_pend_data;
            w_act_dp_nxt   = load ? dp_in   : r_pend_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
        end else begin
            if (load) begin
                r_pend_data <= data_in;
                r_pend_dp   <= dp_in;
            end
            r_act_data <= w_act_data_nxt;
            r_act_dp   <= w_act_dp_nxt;
        end
    end

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        logic w_upper_zero;
        w_upper_zero = 1'b1;
        w_lz         = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero && (w_act_data_nxt[4*i +: 4] == 4'd0);
            w_lz[i]      = blank_lz && (i != 0) && w_upper_zero;
        end
    end

    always_comb begin
        w_nibble = '0;
        w_dp_sel = 1'b0;
        w_blank  = 1'b0;
        w_an_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IW'(i)) begin
                w_nibble    = w_act_data_nxt[4*i +: 4];
                w_dp_sel    = w_act_dp_nxt[i];
                w_blank     = w_lz[i];
                w_an_nxt[i] = 1'b0;
            end
        end
    end

    seg_decoder u_seg_decoder (
        .i_nibble   (w_nibble),
        .i_hex_mode (HEX_MODE != 0),
        .o_seg      (w_dec_seg)
    );

    assign w_seg_hi = w_blank ? SEG_BLANK : w_dec_seg;

    // Outputs are built from next-cycle index and data so they land together
    // with the new slot; disabled or in reset, every select stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an    <= '1;
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_frame <= 1'b0;
        end else if (enable) begin
            r_an    <= w_an_nxt;
            r_seg   <= seg_drive(w_seg_hi, ACT_LOW);
            r_dp    <= ACT_LOW ? ~w_dp_sel : w_dp_sel;
            r_frame <= w_wrap;
        end else begin
            r_an    <= '1;
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_frame <= 1'b0;
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign frame_start = r_frame;

endmodule

// File: doc/display_multiplexado.md
DISPLAY_MULTIPLEXADO -- requirements
Module: display_multiplexado

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (>=2).
REQ-003 SHALL have parameter HEX_MODE, default 1; 1 = show nibbles 0-F, 0 = BCD only.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1; 1 = segment and dp outputs low-true.
REQ-005 SHALL have port clk, input, 1, system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1, scan enable.
REQ-008 SHALL have port load, input, 1, one-cycle strobe capturing data_in and dp_in.
REQ-009 SHALL have port data_in, input, 4*NUM_DIGITS, one nibble per digit; bits [3:0] = digit 0, the least significant.
REQ-010 SHALL have port dp_in, input, NUM_DIGITS, decimal point per digit.
REQ-011 SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-012 SHALL have port seg, output, 7, segments {g,f,e,d,c,b,a}.
REQ-013 SHALL have port dp, output, 1, decimal point segment.
REQ-014 SHALL have port an, output, NUM_DIGITS, digit selects, always active-low.
REQ-015 SHALL have port frame_start, output, 1, one-cycle pulse when scan returns to digit 0.

Function
REQ-016 Prescaler SHALL count 0..REFRESH_DIV-1 while enable=1 and assert an internal tick at REFRESH_DIV-1, then wrap to 0.
REQ-017 On tick, the digit index SHALL increment, wrapping NUM_DIGITS-1 -> 0.
REQ-018 seg, dp, an and frame_start SHALL be registered, reflecting the new index one cycle after the tick.
REQ-019 an[i] SHALL be 0 only when the index equals i; exactly one bit is low while enable=1.
REQ-020 load=1 SHALL capture data_in/dp_in into a pending register; active register SHALL copy pending on the tick that wraps the index to 0 (tear-free update).
REQ-021 If load and the wrap tick coincide, the active register SHALL take data_in/dp_in directly.
REQ-022 Active-high decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-023 With HEX_MODE=0, nibbles A-F SHALL display 40 (dash).
REQ-024 With blank_lz=1, digit i>0 SHALL be blanked (all segments off) when it and every more significant digit are zero; digit 0 is never blanked; dp is unaffected by blanking.
REQ-025 With SEG_ACTIVE_LOW=1, seg and dp SHALL be the bitwise inverse of the active-high pattern.
REQ-026 enable=0 SHALL hold prescaler and index, drive an all ones and seg/dp off, and suppress frame_start; loads SHALL still be captured.
REQ-027 When enable returns to 1, scanning SHALL resume from the held index and prescaler values.
REQ-028 frame_start SHALL pulse for exactly one cycle, coincident with the first output cycle for digit 0.

Reset
REQ-029 rst_n low SHALL immediately clear prescaler, index, pending and active registers, and frame_start.
REQ-030 During reset an SHALL be all ones, and seg and dp SHALL be off (7F/1 when active-low).
REQ-031 After release, the first tick SHALL occur REFRESH_DIV cycles later; reset mid-scan SHALL abort the frame without glitching an low.

Structure
REQ-032 A shared package display_pkg SHALL hold the 16-entry segment table, the DASH and BLANK constants, and the segment bit-order definition.
REQ-033 Nibble-to-segment decode SHALL be a combinational sub-module seg_decoder (nibble, hex_mode -> 7-bit active-high), instantiated once on the selected digit.

Verification
REQ-034 Use REFRESH_DIV=4 and NUM_DIGITS=4. Reset, then load 1234 with enable=1: an cycles E,D,B,7 every 4 cycles. seg (active-low) shows 4,3,2,1 as 19,30,24,79, one per slot. frame_start pulses each 16 cycles.
REQ-035 Load 0012 mid-frame: the displayed digits stay 1234 until the wrap. From the next frame, with blank_lz=1, digits 3 and 2 show 7F and digits 1 and 0 show 79 and 24.
REQ-036 With HEX_MODE=0, load 00AF: digits 1 and 0 show 3F (dash, active-low). With HEX_MODE=1, the same load shows 08 and 0E.
REQ-037 Load 0000 with blank_lz=1: digit 0 shows 40 (active-low zero) and all other digits show 7F. Set dp_in=0100: dp is low in slot 2 although that digit is blanked.
REQ-038 Drop enable for 10 cycles mid-slot: an=F, seg=7F, and there is no frame_start pulse. The scan then resumes on the same digit with the remaining prescaler count.
REQ-039 Assert rst_n low asynchronously mid-slot: an=F and seg=7F immediately. After release, digit 0 is selected and shows 40 (active data cleared to 0, blank_lz=0).
